key_debounce: RTL and testbench

- Pushbutton conditioning stage directly upstream of the LED blinker/indicator logic.
- Synchronises the raw active-low KEY input to clk and debounces it.
- Produces a clean level, single-cycle press, release and long-press event pulses, plus a wrapping press counter that downstream LED logic uses for mode and rate selection.
- Runs on the 50 MHz board clock.

---
 rtl/key_debounce.sv | 85 ++++++++
 tb/tb_key_debounce.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces an active-low pushbutton.
// Outputs a clean level, press/release/long-press strobes and a wrapping press count.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             key_n,
   output logic             key_level,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             long_pulse,
   output logic [CNT_W-1:0] press_count
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 2);
   typedef enum logic [1:0] {IDLE, ARMING, HELD, DISARMING} state_t;
   state_t          r_state;
   logic            r_s1, r_s2;
   logic [DW-1:0]   r_dcnt;
   logic [HW-1:0]   r_hcnt;
   logic            w_pressed;
   assign w_pressed = ~r_s2;
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         r_s1          <= 1'b1;
         r_s2          <= 1'b1;
         r_state       <= IDLE;
         r_dcnt        <= '0;
         r_hcnt        <= '0;
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= '0;
      end else begin
         r_s1          <= key_n;
         r_s2          <= r_s1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         case (r_state)
            IDLE: if (w_pressed) begin
               r_state <= ARMING;
               r_dcnt  <= DW'(1);
            end
            ARMING: if (!w_pressed) begin
               r_state <= IDLE;
               r_dcnt  <= '0;
            end else if (r_dcnt == D_LAST) begin
               r_state     <= HELD;
               key_level   <= 1'b1;
               press_pulse <= 1'b1;
               press_count <= press_count + CNT_W'(1);
               r_dcnt      <= '0;
               r_hcnt      <= '0;
            end else r_dcnt <= r_dcnt + DW'(1);
            HELD: if (!w_pressed) begin
               r_state <= DISARMING;
               r_dcnt  <= DW'(1);
            end else if (r_hcnt != H_LAST) begin
               r_hcnt     <= r_hcnt + HW'(1);
               long_pulse <= (r_hcnt == H_PRE);
            end
            // hcnt is left untouched here so a release bounce resumes the long-press timer
            DISARMING: if (w_pressed) begin
               r_state <= HELD;
               r_dcnt  <= '0;
            end else if (r_dcnt == D_LAST) begin
               r_state       <= IDLE;
               key_level     <= 1'b0;
               release_pulse <= 1'b1;
               r_dcnt        <= '0;
               r_hcnt        <= '0;
            end else r_dcnt <= r_dcnt + DW'(1);
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed vectors for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, CNT_W=2.
module tb_key_debounce;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_n = 1'b1;
   logic       key_level, press_pulse, release_pulse, long_pulse;
   logic [1:0] press_count;
   int n_vec = 0, n_bad = 0;
   int n_press = 0, n_rel = 0, n_long = 0, n_coinc = 0;
   key_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .CNT_W(2)) dut (
      .clk(clk), .Rst(rst), .key_n(key_n), .key_level(key_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .press_count(press_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         n_press += int'(press_pulse);
         n_rel   += int'(release_pulse);
         n_long  += int'(long_pulse);
         n_coinc += int'(long_pulse & release_pulse);
      end
   endtask
   task automatic clr();
      n_press = 0; n_rel = 0; n_long = 0;
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_lvl"}, key_level, 0);
      chk({tag, "_pp"}, press_pulse, 0);
      chk({tag, "_rp"}, release_pulse, 0);
      chk({tag, "_lp"}, long_pulse, 0);
      chk({tag, "_cnt"}, press_count, 0);
   endtask
   initial begin
      step(3);
      chk_zero("reset");
      rst = 1'b0;
      step(2);
      // clean press, long press, release
      clr();
      key_n = 1'b0;
      step(5);
      chk("press_lvl_e5", key_level, 0);
      step(1);
      chk("press_lvl_e6", key_level, 1);
      chk("press_pp_e6", press_pulse, 1);
      chk("press_cnt", press_count, 1);
      step(1);
      chk("press_pp_e7", press_pulse, 0);
      step(7);
      chk("long_e14", long_pulse, 0);
      step(1);
      chk("long_e15", long_pulse, 1);
      step(1);
      chk("long_e16", long_pulse, 0);
      step(50);
      chk("long_once", n_long, 1);
      key_n = 1'b1;
      step(5);
      chk("rel_lvl_e5", key_level, 1);
      step(1);
      chk("rel_lvl_e6", key_level, 0);
      chk("rel_rp_e6", release_pulse, 1);
      step(1);
      chk("rel_rp_e7", release_pulse, 0);
      chk("clean_npress", n_press, 1);
      chk("clean_nrel", n_rel, 1);
      // press bounce: low 3 edges, high 1, then low
      clr();
      key_n = 1'b0;
      step(3);
      key_n = 1'b1;
      step(1);
      key_n = 1'b0;
      step(5);
      chk("bnc_lvl_e5", key_level, 0);
      chk("bnc_nopress", n_press, 0);
      step(1);
      chk("bnc_lvl_e6", key_level, 1);
      chk("bnc_pp", press_pulse, 1);
      chk("bnc_cnt", press_count, 2);
      key_n = 1'b1;
      step(6);
      chk("bnc_rel_lvl", key_level, 0);
      chk("bnc_npress", n_press, 1);
      // release bounce mid-hold delays long_pulse by the frozen edges
      clr();
      key_n = 1'b0;
      step(6);
      chk("hb_lvl", key_level, 1);
      step(5);
      key_n = 1'b1;
      step(1);
      key_n = 1'b0;
      step(4);
      chk("hb_long_e10", long_pulse, 0);
      chk("hb_lvl_held", key_level, 1);
      chk("hb_norel", n_rel, 0);
      step(1);
      chk("hb_long_e11", long_pulse, 1);
      key_n = 1'b1;
      step(6);
      chk("hb_rel_lvl", key_level, 0);
      chk("hb_rel_rp", release_pulse, 1);
      chk("hb_cnt", press_count, 3);
      // counter wrap from a fresh reset
      rst = 1'b1;
      #1;
      chk("wrap_rst_cnt", press_count, 0);
      rst = 1'b0;
      clr();
      for (int i = 0; i < 5; i++) begin
         key_n = 1'b0;
         step(6);
         chk($sformatf("wrap_cnt%0d", i), press_count, (i + 1) % 4);
         key_n = 1'b1;
         step(6);
         chk($sformatf("wrap_rel%0d", i), release_pulse, 1);
      end
      chk("wrap_npress", n_press, 5);
      chk("wrap_nrel", n_rel, 5);
      // reset during ARMING, then during HELD
      key_n = 1'b0;
      step(4);
      rst = 1'b1;
      #1;
      chk_zero("rst_arm");
      rst = 1'b0;
      step(6);
      chk("rst_arm_lvl", key_level, 1);
      chk("rst_arm_cnt", press_count, 1);
      step(4);
      rst = 1'b1;
      #1;
      chk_zero("rst_held");
      rst = 1'b0;
      clr();
      step(5);
      chk("rst_held_lvl_e5", key_level, 0);
      step(1);
      chk("rst_held_lvl_e6", key_level, 1);
      chk("rst_held_pp", press_pulse, 1);
      chk("rst_held_cnt", press_count, 1);
      chk("rst_held_npress", n_press, 1);
      chk("long_rel_coinc", n_coinc, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
